// File: rtl/vector_pkg.sv
// vector_pkg: shared types and Q-format helpers for the reciprocal square root unit.
//   state_e         : controller states of inv_sqrt_nr.
//   seed_a/seed_b   : linear seed coefficients, round(1.6499*2^f) and round(0.4714*2^f).
//   three_half      : 1.5 in Q.f.
//   fp_one          : 1.0 in Q.f.
// Helpers return 64-bit values; callers size them to their data width.
package vector_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_NORM   = 3'd1,
        ST_SEED   = 3'd2,
        ST_NR_SQ  = 3'd3,
        ST_NR_MX  = 3'd4,
        ST_NR_UPD = 3'd5,
        ST_SCALE  = 3'd6,
        ST_DONE   = 3'd7
    } state_e;

    // Round-to-nearest of coefficient/10000 scaled by 2^f.
    function automatic logic [63:0] seed_a(input int unsigned f);
        return ((64'd16499 << f) + 64'd5000) / 64'd10000;
    endfunction

    function automatic logic [63:0] seed_b(input int unsigned f);
        return ((64'd4714 << f) + 64'd5000) / 64'd10000;
    endfunction

    function automatic logic [63:0] three_half(input int unsigned f);
        return (64'd3 << f) >> 1;
    endfunction

    function automatic logic [63:0] fp_one(input int unsigned f);
        return 64'd1 << f;
    endfunction

endpackage

// File: rtl/fx_mul.sv
// fx_mul: combinational unsigned fixed-point multiply.
//   a, b : WIDTH-bit unsigned Q operands.
//   p    : (a*b) >> FRAC_BITS, truncated to WIDTH bits.
module fx_mul #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned FRAC_BITS = 24
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p
);

    logic [2*WIDTH-1:0] full;
    logic               unused_bits;

    assign full = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign p    = full[FRAC_BITS +: WIDTH];

    // Bits below the binary point and above the result word are dropped by design.
    assign unused_bits = ^{full[FRAC_BITS-1:0], full[2*WIDTH-1:FRAC_BITS+WIDTH]};

endmodule

// File: rtl/inv_sqrt_nr.sv
// inv_sqrt_nr: iterative fixed-point 1/sqrt(x).
// Range-reduces x = m * 4^k with m in [0.5, 2), seeds y from a line in m, refines
// y with NR_ITERS Newton-Raphson steps on one shared multiplier, then rescales by 2^-k.
// Ports:
//   clk, rst              : clock, synchronous active-high reset.
//   in_valid/in_ready     : input handshake; in_ready is high only while idle.
//   in_x, in_tag          : operand (unsigned Q(WIDTH-FRAC_BITS).FRAC_BITS) and user tag.
//   out_valid/out_ready   : output handshake; outputs hold while out_ready is low.
//   out_y, out_tag        : result and the tag of its operand.
//   out_sat, out_zero     : result clamped to all-ones; operand was exactly zero.
module inv_sqrt_nr
    import vector_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned FRAC_BITS = 24,
    parameter int unsigned NR_ITERS  = 4,
    parameter int unsigned TAG_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_sat,
    output logic             out_zero
);

    localparam int unsigned LZ_W = $clog2(WIDTH);
    localparam int unsigned K_W  = $clog2(WIDTH) + 2;

    localparam logic [WIDTH-1:0] SEED_A     = WIDTH'(seed_a(FRAC_BITS));
    localparam logic [WIDTH-1:0] SEED_B     = WIDTH'(seed_b(FRAC_BITS));
    localparam logic [WIDTH-1:0] THREE_HALF = WIDTH'(three_half(FRAC_BITS));
    localparam logic [WIDTH-1:0] FP_ONE     = WIDTH'(fp_one(FRAC_BITS));
    localparam logic [2:0]       ITERS      = 3'(NR_ITERS);

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       x_q, x_d;
    logic [TAG_W-1:0]       tag_q, tag_d;
    logic [WIDTH-1:0]       m_q, m_d;
    logic signed [K_W-1:0]  k_q, k_d;
    logic [WIDTH-1:0]       y_q, y_d;
    logic [WIDTH-1:0]       t_q, t_d;
    logic [2:0]             iter_q, iter_d;
    logic                   zero_q, zero_d;

    logic                   out_valid_q, out_valid_d;
    logic [WIDTH-1:0]       out_y_q, out_y_d;
    logic [TAG_W-1:0]       out_tag_q, out_tag_d;
    logic                   out_sat_q, out_sat_d;
    logic                   out_zero_q, out_zero_d;

    logic [WIDTH-1:0]       mul_a, mul_b, mul_p;

    // Range reduction
    logic [LZ_W-1:0]        lead;
    int                     e_int;
    int                     k_int;
    logic [WIDTH-1:0]       m_norm;

    // Final rescale
    logic [K_W-1:0]         neg_k;
    logic [2*WIDTH-1:0]     y_wide;
    logic [WIDTH-1:0]       y_scaled;
    logic                   y_sat;

    fx_mul #(
        .WIDTH    (WIDTH),
        .FRAC_BITS(FRAC_BITS)
    ) u_mul (
        .a(mul_a),
        .b(mul_b),
        .p(mul_p)
    );

    // Leading-one position: ascending scan, so the highest set bit wins.
    always_comb begin
        lead = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (x_q[i]) begin
                lead = LZ_W'(i);
            end
        end
        e_int = int'(lead) - int'(FRAC_BITS);
        // Round odd exponents up so that m lands in [0.5, 1) instead of [2, 4).
        k_int = (e_int + (e_int & 1)) / 2;
        if (k_int >= 0) begin
            m_norm = x_q >> (2 * k_int);
        end else begin
            m_norm = x_q << (-2 * k_int);
        end
    end

    // Rescale y by 2^-k; left shifts go through a double-width word to catch overflow.
    always_comb begin
        neg_k  = -k_q;
        y_wide = {{WIDTH{1'b0}}, y_q} << neg_k;
        y_sat  = 1'b0;
        if (zero_q) begin
            y_scaled = '1;
            y_sat    = 1'b1;
        end else if (!k_q[K_W-1]) begin
            y_scaled = y_q >> k_q;
        end else if (|y_wide[2*WIDTH-1:WIDTH]) begin
            y_scaled = '1;
            y_sat    = 1'b1;
        end else begin
            y_scaled = y_wide[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        tag_d       = tag_q;
        m_d         = m_q;
        k_d         = k_q;
        y_d         = y_q;
        t_d         = t_q;
        iter_d      = iter_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_tag_d   = out_tag_q;
        out_sat_d   = out_sat_q;
        out_zero_d  = out_zero_q;
        mul_a       = '0;
        mul_b       = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    x_d     = in_x;
                    tag_d   = in_tag;
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                if (x_q == '0) begin
                    zero_d = 1'b1;
                    m_d    = FP_ONE;
                    k_d    = '0;
                end else begin
                    zero_d = 1'b0;
                    m_d    = m_norm;
                    k_d    = k_int[K_W-1:0];
                end
                state_d = ST_SEED;
            end
            ST_SEED: begin
                mul_a   = SEED_B;
                mul_b   = m_q;
                y_d     = SEED_A - mul_p;
                iter_d  = '0;
                state_d = ST_NR_SQ;
            end
            ST_NR_SQ: begin
                mul_a   = y_q;
                mul_b   = y_q;
                t_d     = mul_p;
                state_d = ST_NR_MX;
            end
            ST_NR_MX: begin
                mul_a   = m_q;
                mul_b   = t_q;
                t_d     = mul_p;
                state_d = ST_NR_UPD;
            end
            ST_NR_UPD: begin
                // y <- y * (1.5 - m*y^2/2)
                mul_a   = y_q;
                mul_b   = THREE_HALF - (t_q >> 1);
                y_d     = mul_p;
                iter_d  = iter_q + 3'd1;
                state_d = (iter_d < ITERS) ? ST_NR_SQ : ST_SCALE;
            end
            ST_SCALE: begin
                out_y_d     = y_scaled;
                out_sat_d   = y_sat;
                out_zero_d  = zero_q;
                out_tag_d   = tag_q;
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            tag_q       <= '0;
            m_q         <= '0;
            k_q         <= '0;
            y_q         <= '0;
            t_q         <= '0;
            iter_q      <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_tag_q   <= '0;
            out_sat_q   <= 1'b0;
            out_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            tag_q       <= tag_d;
            m_q         <= m_d;
            k_q         <= k_d;
            y_q         <= y_d;
            t_q         <= t_d;
            iter_q      <= iter_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_tag_q   <= out_tag_d;
            out_sat_q   <= out_sat_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_tag   = out_tag_q;
    assign out_sat   = out_sat_q;
    assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_inv_sqrt_nr.sv
// tb_inv_sqrt_nr: directed bench for inv_sqrt_nr with a real-arithmetic reference model.
module tb_inv_sqrt_nr;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned FRAC_BITS = 24;
    localparam int unsigned NR_ITERS  = 4;
    localparam int unsigned TAG_W     = 8;
    localparam int          LATENCY   = 3 + 3 * NR_ITERS;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic [TAG_W-1:0] out_tag;
    logic             out_sat;
    logic             out_zero;

    always #5 clk = ~clk;

    inv_sqrt_nr #(
        .WIDTH    (WIDTH),
        .FRAC_BITS(FRAC_BITS),
        .NR_ITERS (NR_ITERS),
        .TAG_W    (TAG_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_y    (out_y),
        .out_tag  (out_tag),
        .out_sat  (out_sat),
        .out_zero (out_zero)
    );

    typedef struct {
        logic [63:0]      y;
        logic [TAG_W-1:0] tag;
        logic             sat;
        logic             zero;
        int               hs_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   rd_idx   = 0;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input logic [63:0] act,
                         input logic [63:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: y = 2^F / sqrt(x / 2^F), rounded; clamp to all-ones if it does not fit.
    function automatic void model(input logic [WIDTH-1:0] x, output logic [63:0] y,
                                  output logic sat, output logic zero);
        real xr, yr;
        if (x == 0) begin
            y    = 64'hFFFF_FFFF;
            sat  = 1'b1;
            zero = 1'b1;
            return;
        end
        zero = 1'b0;
        xr   = real'(x) / (2.0 ** FRAC_BITS);
        yr   = (2.0 ** FRAC_BITS) / $sqrt(xr);
        if (yr >= 2.0 ** WIDTH) begin
            y   = 64'hFFFF_FFFF;
            sat = 1'b1;
        end else begin
            y   = 64'(longint'(yr));
            sat = 1'b0;
        end
    endfunction

    // Allowed error: 16 LSB floor plus 2^-20 relative.
    function automatic longint tol(input logic [63:0] y);
        return 64'd16 + (y >> 20);
    endfunction

    // Single compare process: every cycle out_valid is high.
    initial begin : compare
        exp_t   e;
        bit     first = 1'b1;
        logic [WIDTH-1:0] prev_y = '0;
        logic [TAG_W-1:0] prev_tag = '0;
        longint d;
        forever begin
            @(negedge clk);
            if (rst) begin
                rd_idx = exp_q.size();
                first  = 1'b1;
            end else if (out_valid) begin
                check("in_ready_low_while_valid", in_ready == 1'b0, 64'(in_ready), 64'd0);
                if (rd_idx >= exp_q.size()) begin
                    check("unexpected_out_valid", 1'b0, 64'(out_y), 64'd0);
                end else begin
                    e = exp_q[rd_idx];
                    if (first) begin
                        check("latency", (cyc - e.hs_cyc) == LATENCY,
                              64'(cyc - e.hs_cyc), 64'(LATENCY));
                    end else begin
                        check("out_y_stable", out_y == prev_y, 64'(out_y), 64'(prev_y));
                        check("out_tag_stable", out_tag == prev_tag, 64'(out_tag),
                              64'(prev_tag));
                    end
                    d = longint'(64'(out_y)) - longint'(e.y);
                    if (d < 0) d = -d;
                    if (e.sat) check("out_y_sat", 64'(out_y) == e.y, 64'(out_y), e.y);
                    else       check("out_y", d <= tol(e.y), 64'(out_y), e.y);
                    check("out_tag", out_tag == e.tag, 64'(out_tag), 64'(e.tag));
                    check("out_sat", out_sat == e.sat, 64'(out_sat), 64'(e.sat));
                    check("out_zero", out_zero == e.zero, 64'(out_zero), 64'(e.zero));
                    prev_y   = out_y;
                    prev_tag = out_tag;
                    first    = 1'b0;
                    if (out_ready) begin
                        rd_idx++;
                        first = 1'b1;
                    end
                end
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] x, input logic [TAG_W-1:0] tag,
                        output int hs);
        exp_t e;
        bit   done = 1'b0;
        hs = -1;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_x     = x;
        in_tag   = tag;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                model(x, e.y, e.sat, e.zero);
                e.tag    = tag;
                e.hs_cyc = cyc + 1;
                hs       = cyc + 1;
                exp_q.push_back(e);
                done     = 1'b1;
            end
        end
        if (!done) check("in_ready_timeout", 1'b0, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (rd_idx == exp_q.size() && !out_valid) done = 1'b1;
        end
        if (!done) check("result_timeout", 1'b0, 64'(rd_idx), 64'(exp_q.size()));
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [WIDTH-1:0] vec_x [10] = '{32'h0100_0000, 32'h0400_0000, 32'h0040_0000,
                                     32'h0200_0000, 32'h0000_0000, 32'h0000_0001,
                                     32'hFFFF_FFFF, 32'h0001_0000, 32'h0300_0000,
                                     32'h0012_3456};

    initial begin : main
        logic [63:0] my;
        logic        ms, mz;
        int          hs;
        bit          seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready == 1'b1, 64'(in_ready), 64'd1);
        check("rst_out_valid", out_valid == 1'b0, 64'(out_valid), 64'd0);
        check("rst_out_y", out_y == '0, 64'(out_y), 64'd0);
        check("rst_out_tag", out_tag == '0, 64'(out_tag), 64'd0);
        check("rst_out_sat", out_sat == 1'b0, 64'(out_sat), 64'd0);
        check("rst_out_zero", out_zero == 1'b0, 64'(out_zero), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Pin the reference model to hand-computed values.
        model(32'h0100_0000, my, ms, mz);
        check("model_1p0", my == 64'h0100_0000, my, 64'h0100_0000);
        model(32'h0400_0000, my, ms, mz);
        check("model_4p0", my == 64'h0080_0000, my, 64'h0080_0000);
        model(32'h0040_0000, my, ms, mz);
        check("model_0p25", my == 64'h0200_0000, my, 64'h0200_0000);
        model(32'h0200_0000, my, ms, mz);
        check("model_2p0", my == 64'h00B5_04F3, my, 64'h00B5_04F3);
        model(32'h0900_0000, my, ms, mz);
        check("model_9p0", my == 64'h0055_5555, my, 64'h0055_5555);
        model(32'h0000_0001, my, ms, mz);
        check("model_tiny_sat", ms == 1'b1 && mz == 1'b0, {62'd0, ms, mz}, 64'd2);

        // Directed vectors with immediate consumer.
        foreach (vec_x[i]) begin
            send(vec_x[i], TAG_W'(8'h10 + i), hs);
            wait_idle();
        end

        // Back-pressure: hold out_ready low for 5 valid cycles.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(32'h0500_0000, 8'hA5, hs);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        if (!seen) check("bp_valid_timeout", 1'b0, 64'(out_valid), 64'd1);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_in_ready", in_ready == 1'b1, 64'(in_ready), 64'd1);
        check("bp_release_out_valid", out_valid == 1'b0, 64'(out_valid), 64'd0);
        wait_idle();

        // Abort in NR_MX of the second iteration (handshake edge + 6).
        send(32'h0400_0000, 8'h5A, hs);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (cyc == hs + 6) seen = 1'b1;
        end
        if (!seen) check("abort_sync_timeout", 1'b0, 64'(cyc), 64'(hs + 6));
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_in_ready", in_ready == 1'b1, 64'(in_ready), 64'd1);
        check("abort_out_valid", out_valid == 1'b0, 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        // Aborted result must never appear.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("abort_no_output", out_valid == 1'b0, 64'(out_valid), 64'd0);
        end

        send(32'h0900_0000, 8'h99, hs);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
